ram_port_arbiter: RTL and testbench

//  Shares the single-port 128x8 data RAM between the CPU datapath (cpu_*) and a

---
 rtl/ram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU datapath and the debug/loader master.
// CPU has priority; a starvation counter and a debug lock guarantee debug progress.
module ram_port_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    S_NORMAL   = 1'b0,
    S_DBG_LOCK = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              cpu_gnt_s;
  logic              dbg_gnt_s;
  logic              cpu_rvalid_r;
  logic              dbg_rvalid_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_NORMAL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: enter lock on a locked debug grant, leave when lock drops
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_NORMAL: begin
        if (dbg_gnt_s && dbg_lock) begin
          state_s = S_DBG_LOCK;
        end else begin
          state_s = S_NORMAL;
        end
      end
      S_DBG_LOCK: begin
        if (!dbg_lock) begin
          state_s = S_NORMAL;
        end else begin
          state_s = S_DBG_LOCK;
        end
      end
      default: state_s = S_NORMAL;
    endcase
  end

  // Grant decode; grants are forced low while reset is held
  always_comb begin
    cpu_gnt_s = 1'b0;
    dbg_gnt_s = 1'b0;
    if (rst) begin
      cpu_gnt_s = 1'b0;
      dbg_gnt_s = 1'b0;
    end else begin
      case (state_r)
        S_NORMAL: begin
          if (dbg_req && (!cpu_req || (starve_cnt_r == STARVE_LIM))) begin
            dbg_gnt_s = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
          end else begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
          end
        end
        S_DBG_LOCK: begin
          cpu_gnt_s = 1'b0;
          dbg_gnt_s = dbg_req;
        end
        default: begin
          cpu_gnt_s = 1'b0;
          dbg_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // RAM port mux: the winner drives address/data, idle drives zeros
  always_comb begin
    ram_en   = 1'b0;
    ram_addr = {ADDR_W{1'b0}};
    ram_data = {DATA_W{1'b0}};
    if (dbg_gnt_s) begin
      ram_en   = dbg_we;
      ram_addr = dbg_addr;
      ram_data = dbg_wdata;
    end else if (cpu_gnt_s) begin
      ram_en   = cpu_we;
      ram_addr = cpu_addr;
      ram_data = cpu_wdata;
    end else begin
      ram_en   = 1'b0;
      ram_addr = {ADDR_W{1'b0}};
      ram_data = {DATA_W{1'b0}};
    end
  end

  // Starvation counter: counts CPU wins while debug waits, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (dbg_gnt_s || !dbg_req) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (cpu_gnt_s && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + CNT_ONE;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Read-valid tracking: a granted read returns to its owner one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid_r <= 1'b0;
      dbg_rvalid_r <= 1'b0;
    end else begin
      cpu_rvalid_r <= cpu_gnt_s && !cpu_we;
      dbg_rvalid_r <= dbg_gnt_s && !dbg_we;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign cpu_rvalid = cpu_rvalid_r;
  assign dbg_rvalid = dbg_rvalid_r;
  assign cpu_rdata  = cpu_rvalid_r ? ram_q : {DATA_W{1'b0}};
  assign dbg_rdata  = dbg_rvalid_r ? ram_q : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model and a behavioural RAM.
module tb_ram_port_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = 7'd0;
  logic [DATA_W-1:0] cpu_wdata = 8'd0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = 7'd0;
  logic [DATA_W-1:0] dbg_wdata = 8'd0;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q = 8'd0;

  int errors = 0;
  int checks = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural write-first RAM driven by the DUT's RAM port
  logic [7:0] ram_mem [0:127];
  logic       clear_mem = 1'b1;
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= 8'd0;
      ram_q <= 8'd0;
    end else begin
      if (ram_en) ram_mem[ram_addr] <= ram_data;
      ram_q <= ram_en ? ram_data : ram_mem[ram_addr];
    end
  end

  // Reference model: ownership, debug waiting count, shadow memory, pending read
  logic       ref_locked;
  int         ref_waits;
  logic [7:0] ref_mem [0:127];
  int         ref_rd_owner;     // 0 none, 1 cpu, 2 dbg
  logic [7:0] ref_rd_data;
  logic       e_cpu, e_dbg;
  logic [35:0] exp_vec;

  function automatic logic [35:0] observed();
    return {cpu_gnt, dbg_gnt, ram_en, ram_addr, ram_data,
            cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata};
  endfunction

  task automatic model_reset();
    ref_locked   = 1'b0;
    ref_waits    = 0;
    ref_rd_owner = 0;
    ref_rd_data  = 8'd0;
  endtask

  task automatic model_eval();
    logic       en;
    logic [6:0] a;
    logic [7:0] d;
    e_dbg = ref_locked ? dbg_req : (dbg_req && (!cpu_req || ref_waits >= STARVE_MAX));
    e_cpu = !ref_locked && !e_dbg && cpu_req;
    en = 1'b0; a = 7'd0; d = 8'd0;
    if (e_dbg) begin en = dbg_we; a = dbg_addr; d = dbg_wdata; end
    else if (e_cpu) begin en = cpu_we; a = cpu_addr; d = cpu_wdata; end
    exp_vec = {e_cpu, e_dbg, en, a, d,
               ref_rd_owner == 1, (ref_rd_owner == 1) ? ref_rd_data : 8'd0,
               ref_rd_owner == 2, (ref_rd_owner == 2) ? ref_rd_data : 8'd0};
  endtask

  task automatic model_commit();
    ref_rd_owner = 0;
    if (e_dbg) begin
      if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      else begin ref_rd_owner = 2; ref_rd_data = ref_mem[dbg_addr]; end
    end else if (e_cpu) begin
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else begin ref_rd_owner = 1; ref_rd_data = ref_mem[cpu_addr]; end
    end
    if (!dbg_req || e_dbg) ref_waits = 0;
    else if (e_cpu && ref_waits < STARVE_MAX) ref_waits = ref_waits + 1;
    ref_locked = ref_locked ? dbg_lock : (e_dbg && dbg_lock);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic new_cpu();
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = 7'($urandom_range(0, 127));
    cpu_wdata = 8'($urandom);
  endtask

  task automatic new_dbg();
    dbg_we    = 1'($urandom_range(0, 1));
    dbg_addr  = 7'($urandom_range(0, 127));
    dbg_wdata = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_mem = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
    @(negedge clk); #1;
    if (observed() !== 36'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", observed(), 36'd0);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0; clear_mem = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'd0;
    settle();
    if (observed() !== exp_vec) begin
      errors++; $display("FAIL after_reset: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
  endtask

  task automatic test_cpu_write_read();
    dbg_req = 1'b0; dbg_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h10; cpu_wdata = 8'h5A;
    settle();
    if (observed() !== exp_vec || cpu_gnt !== 1'b1 || ram_en !== 1'b1) begin
      errors++; $display("FAIL cpu_write: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
    cpu_we = 1'b0;
    settle();
    if (observed() !== exp_vec || cpu_gnt !== 1'b1 || ram_en !== 1'b0) begin
      errors++; $display("FAIL cpu_read: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
    cpu_req = 1'b0;
    settle();
    if (observed() !== exp_vec || cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin
      errors++; $display("FAIL cpu_read_data: got rvalid=%b data=%h expected 1 5a", cpu_rvalid, cpu_rdata);
    end
    checks++;
    tick();
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b0;
    new_cpu(); new_dbg();
    for (int i = 0; i < 20; i++) begin
      settle();
      if (observed() !== exp_vec) begin
        errors++; $display("FAIL starve_vec %0d: got %h expected %h", i, observed(), exp_vec);
      end
      checks++;
      if (dbg_gnt !== ((i % 5) == 4)) begin
        errors++; $display("FAIL starve_pattern %0d: got dbg_gnt=%b expected %b", i, dbg_gnt, (i % 5) == 4);
      end
      checks++;
      tick();
      if (e_cpu) new_cpu();
      if (e_dbg) new_dbg();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    settle();
    if (observed() !== exp_vec) begin
      errors++; $display("FAIL starve_drain: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
  endtask

  task automatic test_lock_burst();
    int grants = 0;
    int cyc = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h40;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b1; dbg_addr = 7'h00;
    while (grants < 4 && cyc < 40) begin
      settle();
      if (observed() !== exp_vec) begin
        errors++; $display("FAIL lock_vec %0d: got %h expected %h", cyc, observed(), exp_vec);
      end
      checks++;
      if (grants > 0 && cpu_gnt !== 1'b0) begin
        errors++; $display("FAIL lock_cpu_blocked %0d: got cpu_gnt=%b expected 0", cyc, cpu_gnt);
      end
      checks++;
      tick();
      if (e_dbg) begin grants++; dbg_addr = dbg_addr + 7'd1; end
      cyc++;
    end
    if (grants != 4) begin
      errors++; $display("FAIL lock_burst_grants: got %0d expected 4", grants);
    end
    checks++;
    dbg_req = 1'b0; dbg_lock = 1'b0;
    settle();
    if (observed() !== exp_vec || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL lock_drop: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
    settle();
    if (observed() !== exp_vec || cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL lock_release: got cpu_gnt=%b expected 1", cpu_gnt);
    end
    checks++;
    tick();
    cpu_req = 1'b0;
    settle();
    tick();
  endtask

  task automatic test_alternating();
    logic [1:0] exp_rv;
    dbg_req = 1'b0; dbg_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h20; cpu_wdata = 8'h11;
    settle(); tick();
    cpu_addr = 7'h21; cpu_wdata = 8'h22;
    settle(); tick();
    cpu_we = 1'b0; dbg_we = 1'b0; cpu_addr = 7'h20; dbg_addr = 7'h21;
    for (int k = 0; k < 8; k++) begin
      cpu_req = ((k % 2) == 0);
      dbg_req = ((k % 2) == 1);
      settle();
      if (observed() !== exp_vec) begin
        errors++; $display("FAIL alt_vec %0d: got %h expected %h", k, observed(), exp_vec);
      end
      checks++;
      exp_rv = (k == 0) ? 2'b00 : (((k % 2) == 1) ? 2'b10 : 2'b01);
      if ({cpu_rvalid, dbg_rvalid} !== exp_rv) begin
        errors++; $display("FAIL alt_route %0d: got rvalids=%b expected %b", k, {cpu_rvalid, dbg_rvalid}, exp_rv);
      end
      checks++;
      if (k > 0 && ((k % 2) == 1) && cpu_rdata !== 8'h11) begin
        errors++; $display("FAIL alt_cpu_data %0d: got %h expected 11", k, cpu_rdata);
      end
      if (k > 0 && ((k % 2) == 0) && dbg_rdata !== 8'h22) begin
        errors++; $display("FAIL alt_dbg_data %0d: got %h expected 22", k, dbg_rdata);
      end
      if (k > 0) checks++;
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    settle();
    if (observed() !== exp_vec || dbg_rdata !== 8'h22) begin
      errors++; $display("FAIL alt_last: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = 7'h21;
    settle();
    if (observed() !== exp_vec) begin
      errors++; $display("FAIL rst_pre: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
    rst = 1'b1;
    #1;
    if (observed() !== 36'd0) begin
      errors++; $display("FAIL rst_async: got %h expected %h", observed(), 36'd0);
    end
    checks++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (observed() !== exp_vec) begin
        errors++; $display("FAIL rst_post_vec %0d: got %h expected %h", i, observed(), exp_vec);
      end
      checks++;
      if (dbg_gnt !== ((i % 5) == 4) || (i == 0 && cpu_rvalid !== 1'b0)) begin
        errors++; $display("FAIL rst_post_state %0d: got dbg_gnt=%b rvalid=%b", i, dbg_gnt, cpu_rvalid);
      end
      checks++;
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    settle(); tick();
  endtask

  task automatic test_starve_restart();
    int cpu_wins = 0;
    int cyc = 0;
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b0;
    new_cpu(); new_dbg();
    for (int i = 0; i < 3; i++) begin
      settle();
      if (observed() !== exp_vec || cpu_gnt !== 1'b1) begin
        errors++; $display("FAIL restart_pre %0d: got %h expected %h", i, observed(), exp_vec);
      end
      checks++;
      tick();
      new_cpu();
    end
    dbg_req = 1'b0;
    settle(); tick(); new_cpu();
    dbg_req = 1'b1;
    while (cyc < 10) begin
      settle();
      if (observed() !== exp_vec) begin
        errors++; $display("FAIL restart_vec %0d: got %h expected %h", cyc, observed(), exp_vec);
      end
      checks++;
      if (dbg_gnt === 1'b1) break;
      if (cpu_gnt === 1'b1) cpu_wins++;
      tick();
      new_cpu();
      cyc++;
    end
    if (cpu_wins != 4) begin
      errors++; $display("FAIL restart_count: got %0d cpu wins expected 4", cpu_wins);
    end
    checks++;
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    settle(); tick();
  endtask

  task automatic test_random();
    new_cpu(); new_dbg();
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      dbg_lock = ($urandom_range(0, 3) == 0);
      settle();
      if (observed() !== exp_vec) begin
        errors++; $display("FAIL random_vec %0d: got %h expected %h", i, observed(), exp_vec);
      end
      checks++;
      tick();
      if (e_cpu || !cpu_req) begin cpu_req = ($urandom_range(0, 3) != 0); new_cpu(); end
      if (e_dbg || !dbg_req) begin dbg_req = ($urandom_range(0, 2) != 0); new_dbg(); end
    end
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    settle();
    if (observed() !== exp_vec) begin
      errors++; $display("FAIL random_drain: got %h expected %h", observed(), exp_vec);
    end
    checks++;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cpu_write_read();
    test_starvation();
    test_lock_burst();
    test_alternating();
    test_reset_mid_read();
    test_starve_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
